prf_freelist_ctrl: RTL

//  Physical-register free-list manager and allocation arbiter for the 2-way rename stage.

---
 rtl/prf_freelist_if.sv | 25 ++
 rtl/prf_freelist_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prf_freelist_if.sv
// Rename-stage bundle between the dispatch/retire front end and the PRF free-list manager.
// master = front end driving requests and releases, slave = free-list controller.
interface prf_freelist_if #(
    parameter int unsigned PRF_IDX = 6
) ();
    logic                   flush;
    logic [1:0]             alloc_req;
    logic [1:0]             alloc_gnt;
    logic [2*PRF_IDX-1:0]   alloc_pidx;
    logic                   stall;
    logic [1:0]             retire;
    logic [2*PRF_IDX-1:0]   release_pidx;
    logic [PRF_IDX:0]       free_cnt;
    logic                   fl_err;

    modport master (
        output flush, alloc_req, retire, release_pidx,
        input  alloc_gnt, alloc_pidx, stall, free_cnt, fl_err
    );

    modport slave (
        input  flush, alloc_req, retire, release_pidx,
        output alloc_gnt, alloc_pidx, stall, free_cnt, fl_err
    );
endinterface

// File: rtl/prf_freelist_ctrl.sv
// Physical-register free list and 2-way allocation arbiter with one-cycle flush recovery.
// Optional FL_CHECK_EN adds a free bitmap that flags double releases and busy grants on fl_err.
module prf_freelist_ctrl #(
    parameter int unsigned PRF_SZ  = 64,
    parameter int unsigned PRF_IDX = 6,
    parameter int unsigned ARF_SZ  = 32
) (
    input  logic          clk,
    input  logic          reset,
    prf_freelist_if.slave fl_if
);
    localparam int unsigned CNT_W    = PRF_IDX + 1;
    localparam int unsigned SUM_W    = CNT_W + 1;
    localparam int unsigned FREE_MAX = PRF_SZ - ARF_SZ;
    localparam logic [SUM_W-1:0] FREE_MAX_S = SUM_W'(FREE_MAX);

    logic [PRF_IDX-1:0] fl [PRF_SZ];
    logic [PRF_IDX-1:0] head;
    logic [PRF_IDX-1:0] arch_head;
    logic [PRF_IDX-1:0] tail;
    logic [CNT_W-1:0]   free_cnt;

    logic [1:0]         req;
    logic [1:0]         ret;
    logic [1:0]         gnt;
    logic               gnt0;
    logic               flush;
    logic [PRF_IDX-1:0] rel0;
    logic [PRF_IDX-1:0] rel1;
    logic [PRF_IDX-1:0] pidx0;
    logic [PRF_IDX-1:0] pidx1;
    logic [PRF_IDX-1:0] head_p1;
    logic [PRF_IDX-1:0] tail_p1;
    logic [1:0]         n_gnt;
    logic [1:0]         n_ret;
    logic               wr0;
    logic               wr1;
    logic [PRF_IDX-1:0] push0;
    logic [PRF_IDX-1:0] head_nxt;
    logic [PRF_IDX-1:0] arch_head_nxt;
    logic [PRF_IDX-1:0] tail_nxt;
    logic [SUM_W-1:0]   free_sum;
    logic [CNT_W-1:0]   free_cnt_nxt;

    assign req   = fl_if.alloc_req;
    assign ret   = fl_if.retire;
    assign flush = fl_if.flush;
    assign rel0  = fl_if.release_pidx[0 +: PRF_IDX];
    assign rel1  = fl_if.release_pidx[PRF_IDX +: PRF_IDX];

    assign head_p1 = head + PRF_IDX'(1);
    assign tail_p1 = tail + PRF_IDX'(1);

    // Grant arbitration: in-order, only against the registered count, nothing during flush/reset
    always_comb begin
        gnt0 = 1'b0;
        gnt  = 2'b00;
        if (!reset && !flush) begin
            gnt0   = req[0] && (free_cnt != '0);
            gnt[0] = gnt0;
            gnt[1] = req[1] && (req[0] ? (gnt0 && (free_cnt >= CNT_W'(2)))
                                       : (free_cnt != '0));
        end
    end

    assign pidx0 = fl[head];
    assign pidx1 = req[0] ? fl[head_p1] : fl[head];

    assign fl_if.alloc_gnt  = gnt;
    assign fl_if.alloc_pidx = {pidx1, pidx0};
    assign fl_if.stall      = reset ? 1'b0 : |(req & ~gnt);
    assign fl_if.free_cnt   = free_cnt;

    assign n_gnt = {1'b0, gnt[0]} + {1'b0, gnt[1]};
    assign n_ret = {1'b0, ret[0]} + {1'b0, ret[1]};

    // Releases are packed into consecutive tail slots in way order
    assign wr0   = |ret;
    assign wr1   = &ret;
    assign push0 = ret[0] ? rel0 : rel1;

    always_comb begin
        arch_head_nxt = arch_head + PRF_IDX'(n_ret);
        tail_nxt      = tail + PRF_IDX'(n_ret);
        head_nxt      = flush ? arch_head_nxt : head + PRF_IDX'(n_gnt);
        free_sum      = SUM_W'(free_cnt) + SUM_W'(n_ret) - SUM_W'(n_gnt);
        free_cnt_nxt  = CNT_W'(free_sum);
        if (free_sum > FREE_MAX_S) begin
            free_cnt_nxt = CNT_W'(FREE_MAX);
        end
        if (flush) begin
            free_cnt_nxt = CNT_W'(FREE_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PRF_SZ); i++) begin
                fl[i] <= (i < int'(FREE_MAX)) ? PRF_IDX'(int'(ARF_SZ) + i) : '0;
            end
            head      <= '0;
            arch_head <= '0;
            tail      <= PRF_IDX'(FREE_MAX);
            free_cnt  <= CNT_W'(FREE_MAX);
        end else begin
            if (wr0) begin
                fl[tail] <= push0;
            end
            if (wr1) begin
                fl[tail_p1] <= rel1;
            end
            head      <= head_nxt;
            arch_head <= arch_head_nxt;
            tail      <= tail_nxt;
            free_cnt  <= free_cnt_nxt;
        end
    end

`ifdef FL_CHECK_EN
    logic [PRF_SZ-1:0]  free_map;
    logic [PRF_SZ-1:0]  free_map_nxt;
    logic               fl_err;
    logic               err_nxt;
    logic [PRF_IDX-1:0] slot;
    logic [PRF_IDX-1:0] tag;

    // Shadow free bitmap; on flush it is rebuilt from the committed free window
    always_comb begin
        free_map_nxt = free_map;
        err_nxt      = fl_err;
        slot         = '0;
        tag          = '0;
        if (gnt[0]) begin
            if (!free_map[pidx0]) err_nxt = 1'b1;
            free_map_nxt[pidx0] = 1'b0;
        end
        if (gnt[1]) begin
            if (!free_map[pidx1]) err_nxt = 1'b1;
            free_map_nxt[pidx1] = 1'b0;
        end
        if (ret[0]) begin
            if (free_map[rel0]) err_nxt = 1'b1;
            free_map_nxt[rel0] = 1'b1;
        end
        if (ret[1]) begin
            if (free_map[rel1]) err_nxt = 1'b1;
            free_map_nxt[rel1] = 1'b1;
        end
        if ((|ret) && (free_cnt == CNT_W'(FREE_MAX))) begin
            err_nxt = 1'b1;
        end
        if (flush) begin
            free_map_nxt = '0;
            for (int i = 0; i < int'(FREE_MAX); i++) begin
                slot = arch_head_nxt + PRF_IDX'(i);
                if (wr0 && (slot == tail)) begin
                    tag = push0;
                end else if (wr1 && (slot == tail_p1)) begin
                    tag = rel1;
                end else begin
                    tag = fl[slot];
                end
                free_map_nxt[tag] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_map <= {{FREE_MAX{1'b1}}, {ARF_SZ{1'b0}}};
            fl_err   <= 1'b0;
        end else begin
            free_map <= free_map_nxt;
            fl_err   <= err_nxt;
        end
    end

    assign fl_if.fl_err = fl_err;
`else
    assign fl_if.fl_err = 1'b0;
`endif

endmodule
